// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for an N-stage in-order pipeline.
// Tracks which stages hold live instructions, and decides when the pipeline
// steps (run or debug N-step). It inserts load-use bubbles, applies
// branch/jump flushes and counts stalls, flushes and retirements.
module pipe_ctrl #(
    parameter int STAGES     = 5,
    parameter int REG_W      = 5,
    parameter int BR_STAGE   = 3,
    parameter int LU_BUBBLES = 1,
    parameter int STEP_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkEnable,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic [REG_W-1:0]  rs_IFID,
    input  logic [REG_W-1:0]  rt_IFID,
    input  logic              uses_rt_IFID,
    input  logic [REG_W-1:0]  rt_IDEX,
    input  logic              memRead_IDEX,
    input  logic              branchTaken,
    input  logic              jumpFlag,
    output logic              advance,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic              pc_write,
    output logic              bubble_idex,
    output logic [STAGES-1:0] flush_mask,
    output logic              step_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

    // Stages younger than the branch resolve stage (0..BR_STAGE-1).
    localparam logic [STAGES-1:0] BR_MASK = STAGES'((1 << BR_STAGE) - 1);

    state_t              state;
    logic [STEP_W-1:0]   remaining;
    logic [1:0]          luCnt;
    logic [STAGES-1:0]   vldPipe;
    logic [STAGES-1:0]   vldNext;
    logic                luHit;
    logic                stallAny;
    logic                brFlush;
    logic                stallEff;
    logic                jmpFlush;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign advance     = (state == RUN) || (state == STEP);
    assign step_busy   = (state == STEP);
    assign stage_valid = vldPipe;

    assign luHit = vldPipe[1] & vldPipe[2] & memRead_IDEX & (rt_IDEX != '0) &
                   ((rt_IDEX == rs_IFID) | (uses_rt_IFID & (rt_IDEX == rt_IFID)));
    assign stallAny = luHit | (luCnt != 2'd0);

    // Branch beats load-use, and load-use beats jump. A jump held in ID by a
    // stall is simply re-seen on a later cycle.
    assign brFlush  = advance & branchTaken & vldPipe[BR_STAGE];
    assign stallEff = advance & stallAny & ~brFlush;
    assign jmpFlush = advance & jumpFlag & vldPipe[1] & ~brFlush & ~stallEff;

    assign pc_write    = advance & ~stallEff;
    assign bubble_idex = stallEff;

    // Enables: everything steps with advance, except IF/ID hold during a stall.
    always_comb begin
        stage_en = {STAGES{advance}};
        if (stallEff) stage_en[1:0] = 2'b00;
    end

    // flush_mask marks the stages whose current contents are being killed.
    always_comb begin
        flush_mask = '0;
        if (brFlush)       flush_mask = BR_MASK;
        else if (jmpFlush) flush_mask[0] = 1'b1;
    end

    // Next-state valid bits: shift on advance, then apply flush/stall edits.
    // Killed instructions are the ones moving into stages 1..BR_STAGE, and
    // stage 0 takes the freshly fetched target.
    always_comb begin
        vldNext = vldPipe;
        if (advance) begin
            vldNext = {vldPipe[STAGES-2:0], 1'b1};
            if (brFlush) begin
                vldNext[BR_STAGE:1] = '0;
            end else if (stallEff) begin
                vldNext[1:0] = vldPipe[1:0];
                vldNext[2]   = 1'b0;
            end else if (jmpFlush) begin
                vldNext[1] = 1'b0;
            end
        end
    end

    // Exec FSM: free-run vs. counted step sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HALT;
            remaining <= '0;
        end else begin
            case (state)
                HALT: begin
                    if (!step_mode && clkEnable) begin
                        state <= RUN;
                    end else if (step_mode && step_req && (step_count != '0)) begin
                        state     <= STEP;
                        remaining <= step_count;
                    end
                end
                RUN: begin
                    if (!clkEnable || step_mode) state <= HALT;
                end
                STEP: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == STEP_W'(1)) state <= HALT;
                end
                default: state <= HALT;
            endcase
        end
    end

    // Load-use bubble counter; only moves on advance cycles, cleared by a branch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            luCnt <= 2'd0;
        end else if (advance) begin
            if (brFlush)              luCnt <= 2'd0;
            else if (luHit)           luCnt <= 2'(LU_BUBBLES - 1);
            else if (luCnt != 2'd0)   luCnt <= luCnt - 1'b1;
        end
    end

    // Per-stage valid bits.
    always_ff @(posedge clk) begin
        if (!reset) vldPipe <= '0;
        else        vldPipe <= vldNext;
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            stall_cnt   <= satInc(stall_cnt, stallEff);
            flush_cnt   <= satInc(flush_cnt, brFlush | jmpFlush);
            retired_cnt <= satInc(retired_cnt, advance & vldPipe[STAGES-1]);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=5, BR_STAGE=3, LU_BUBBLES=2).
// A second instance with 2-bit counters watches counter saturation.
module tb_pipe_ctrl;

    localparam int STAGES = 5;
    localparam int REG_W  = 5;
    localparam int STEP_W = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetN, clkEnable, stepMode, stepReq;
    logic [STEP_W-1:0] stepCount;
    logic [REG_W-1:0]  rsId, rtId, rtEx;
    logic              usesRt, memRd, brTaken, jmp;

    logic              advance, pcWrite, bubble, stepBusy;
    logic [STAGES-1:0] stageEn, stageValid, flushMask;
    logic [CNT_W-1:0]  stallCnt, flushCnt, retCnt;

    logic              sAdv, sPcw, sBub, sBusy;
    logic [STAGES-1:0] sEn, sVld, sFm;
    logic [1:0]        sStall, sFlush, sRet;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .BR_STAGE(3), .LU_BUBBLES(2),
                .STEP_W(STEP_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(resetN), .clkEnable(clkEnable), .step_mode(stepMode),
        .step_req(stepReq), .step_count(stepCount), .rs_IFID(rsId), .rt_IFID(rtId),
        .uses_rt_IFID(usesRt), .rt_IDEX(rtEx), .memRead_IDEX(memRd),
        .branchTaken(brTaken), .jumpFlag(jmp), .advance(advance), .stage_en(stageEn),
        .stage_valid(stageValid), .pc_write(pcWrite), .bubble_idex(bubble),
        .flush_mask(flushMask), .step_busy(stepBusy), .stall_cnt(stallCnt),
        .flush_cnt(flushCnt), .retired_cnt(retCnt));

    pipe_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .BR_STAGE(3), .LU_BUBBLES(2),
                .STEP_W(STEP_W), .CNT_W(2)) u_sat (
        .clk(clk), .reset(resetN), .clkEnable(clkEnable), .step_mode(stepMode),
        .step_req(stepReq), .step_count(stepCount), .rs_IFID(rsId), .rt_IFID(rtId),
        .uses_rt_IFID(usesRt), .rt_IDEX(rtEx), .memRead_IDEX(memRd),
        .branchTaken(brTaken), .jumpFlag(jmp), .advance(sAdv), .stage_en(sEn),
        .stage_valid(sVld), .pc_write(sPcw), .bubble_idex(sBub),
        .flush_mask(sFm), .step_busy(sBusy), .stall_cnt(sStall),
        .flush_cnt(sFlush), .retired_cnt(sRet));

    typedef struct {
        logic ce;
        logic [REG_W-1:0] rs, rt, rte;
        logic ur, md, br, jp;
        logic adv, pcw, bub;
        logic [STAGES-1:0] en, fm, vld;
        int stl, fls, ret;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic ce, input int rs, input int rt, input logic ur,
                                input int rte, input logic md, input logic br, input logic jp,
                                input logic adv, input logic pcw, input logic bub,
                                input logic [4:0] en, input logic [4:0] fm, input logic [4:0] vld,
                                input int stl, input int fls, input int ret);
        vec_t v;
        v.ce = ce; v.rs = REG_W'(rs); v.rt = REG_W'(rt); v.ur = ur; v.rte = REG_W'(rte);
        v.md = md; v.br = br; v.jp = jp; v.adv = adv; v.pcw = pcw; v.bub = bub;
        v.en = en; v.fm = fm; v.vld = vld; v.stl = stl; v.fls = fls; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clrIn();
        clkEnable = 0; stepMode = 0; stepReq = 0; stepCount = '0;
        rsId = '0; rtId = '0; rtEx = '0; usesRt = 0; memRd = 0; brTaken = 0; jmp = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int advSeen, busySeen;

    initial begin
        // Row: inputs (ce rs rt usesRt rtEx memRd br jmp), then the outputs expected
        // during that cycle (adv pcw bub en fm valid stall flush retired).
        // FSM is registered: advance follows clkEnable by one cycle.
        tbl[0]  = mk(1,0,0,0,0,0,0,0, 0,0,0, 5'b00000,5'b00000,5'b00000, 0,0,0);
        tbl[1]  = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b00000, 0,0,0);
        tbl[2]  = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b00001, 0,0,0);
        tbl[3]  = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b00011, 0,0,0);
        tbl[4]  = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b00111, 0,0,0);
        tbl[5]  = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b01111, 0,0,0);
        tbl[6]  = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b11111, 0,0,0);
        tbl[7]  = mk(0,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b11111, 0,0,1);
        // clkEnable low: HALT holds valid bits and counters.
        tbl[8]  = mk(0,0,0,0,0,0,0,0, 0,0,0, 5'b00000,5'b00000,5'b11111, 0,0,2);
        tbl[9]  = mk(0,0,0,0,0,0,0,0, 0,0,0, 5'b00000,5'b00000,5'b11111, 0,0,2);
        tbl[10] = mk(1,0,0,0,0,0,0,0, 0,0,0, 5'b00000,5'b00000,5'b11111, 0,0,2);
        // Load-use rs match, two bubbles (second from the counter).
        tbl[11] = mk(1,5,0,0,5,1,0,0, 1,0,1, 5'b11100,5'b00000,5'b11111, 0,0,2);
        tbl[12] = mk(1,5,0,0,5,1,0,0, 1,0,1, 5'b11100,5'b00000,5'b11011, 1,0,3);
        tbl[13] = mk(1,5,0,0,5,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b10011, 2,0,4);
        // rt_IDEX = 0 never stalls.
        tbl[14] = mk(1,0,0,0,0,1,0,0, 1,1,0, 5'b11111,5'b00000,5'b00111, 2,0,5);
        // Load-use via rt.
        tbl[15] = mk(1,1,7,1,7,1,0,0, 1,0,1, 5'b11100,5'b00000,5'b01111, 2,0,5);
        // Branch overrides the pending counter-driven stall.
        tbl[16] = mk(1,0,0,0,0,0,1,0, 1,1,0, 5'b11111,5'b00111,5'b11011, 3,0,5);
        tbl[17] = mk(1,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b10001, 3,1,6);
        // Jump with ID valid, then jump with ID empty (no flush).
        tbl[18] = mk(1,0,0,0,0,0,0,1, 1,1,0, 5'b11111,5'b00001,5'b00011, 3,1,7);
        tbl[19] = mk(1,0,0,0,0,0,0,1, 1,1,0, 5'b11111,5'b00000,5'b00101, 3,2,7);
        tbl[20] = mk(0,0,0,0,0,0,0,0, 1,1,0, 5'b11111,5'b00000,5'b01011, 3,2,7);
        tbl[21] = mk(0,0,0,0,0,0,0,0, 0,0,0, 5'b00000,5'b00000,5'b10111, 3,2,7);

        // Reset
        clrIn();
        resetN = 0;
        tick(); tick();
        chk("reset valid", stageValid, 0);
        chk("reset adv", advance, 0);
        chk("reset busy", stepBusy, 0);
        chk("reset en", stageEn, 0);
        chk("reset pcw", pcWrite, 0);
        chk("reset retired", retCnt, 0);
        resetN = 1;

        for (int i = 0; i < 22; i++) begin
            clkEnable = tbl[i].ce; rsId = tbl[i].rs; rtId = tbl[i].rt; usesRt = tbl[i].ur;
            rtEx = tbl[i].rte; memRd = tbl[i].md; brTaken = tbl[i].br; jmp = tbl[i].jp;
            #1;
            chk($sformatf("row%0d adv", i), advance, tbl[i].adv);
            chk($sformatf("row%0d pcw", i), pcWrite, tbl[i].pcw);
            chk($sformatf("row%0d bub", i), bubble, tbl[i].bub);
            chk($sformatf("row%0d en", i), stageEn, tbl[i].en);
            chk($sformatf("row%0d flush_mask", i), flushMask, tbl[i].fm);
            chk($sformatf("row%0d valid", i), stageValid, tbl[i].vld);
            chk($sformatf("row%0d stall_cnt", i), stallCnt, tbl[i].stl);
            chk($sformatf("row%0d flush_cnt", i), flushCnt, tbl[i].fls);
            chk($sformatf("row%0d retired", i), retCnt, tbl[i].ret);
            tick();
        end
        // 2-bit counters: retired (7) saturates at 3; stall=3, flush=2 fit.
        chk("sat retired", sRet, 3);
        chk("sat stall", sStall, 3);
        chk("sat flush", sFlush, 2);

        // Load-use and branch in the same cycle: branch wins, no stall.
        clrIn();
        clkEnable = 1;
        tick();                       // HALT -> RUN
        tick();                       // 10111 -> 01111
        rsId = 5; rtEx = 5; memRd = 1; brTaken = 1;
        #1;
        chk("lu+br flush_mask", flushMask, 5'b00111);
        chk("lu+br bub", bubble, 0);
        chk("lu+br pcw", pcWrite, 1);
        chk("lu+br en", stageEn, 5'b11111);
        tick();
        chk("lu+br stall_cnt", stallCnt, 3);
        chk("lu+br flush_cnt", flushCnt, 3);
        chk("lu+br valid[2:0]", stageValid[2:0], 3'b001);
        clrIn();
        #1;
        chk("lu+br no pending stall", pcWrite, 1);
        tick();                       // RUN -> HALT

        // Step mode from empty pipeline.
        resetN = 0;
        tick();
        resetN = 1; stepMode = 1;
        stepReq = 1; stepCount = 0;  // zero count ignored
        tick();
        chk("step0 busy", stepBusy, 0);
        chk("step0 adv", advance, 0);
        stepCount = 3;
        tick();
        advSeen = 0; busySeen = 0;
        for (int k = 0; k < 8; k++) begin
            stepReq = (k == 1);       // second request while busy
            stepCount = 5;
            #1;
            advSeen += int'(advance);
            busySeen += int'(stepBusy);
            tick();
        end
        stepReq = 0;
        chk("step adv cycles", advSeen, 3);
        chk("step busy cycles", busySeen, 3);
        chk("step valid", stageValid, 5'b00111);

        // Reset mid-step with remaining=4.
        stepReq = 1; stepCount = 6;
        tick();
        stepReq = 0;
        tick(); tick();
        chk("midstep busy", stepBusy, 1);
        resetN = 0;
        tick();
        chk("abort busy", stepBusy, 0);
        chk("abort valid", stageValid, 0);
        chk("abort adv", advance, 0);
        chk("abort stall_cnt", stallCnt, 0);
        chk("abort flush_cnt", flushCnt, 0);
        chk("abort retired", retCnt, 0);
        resetN = 1; stepMode = 0; clkEnable = 0;
        tick(); tick();
        chk("idle busy", stepBusy, 0);
        chk("idle adv", advance, 0);
        chk("idle valid", stageValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
